data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder for the RISC-V core's load/store port.
- Accepts one request at a time through a valid/ready handshake, waits a programmable latency, commits stores, and returns load data through a valid/ready response channel.
- Handles RV64 access sizes and load extension from funct3, replacing the core's combinational data memory.
- Flags misaligned, out-of-range and illegal-size accesses.

---
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle RV64 data memory behind valid/ready request and response channels.
// Accepts one request at a time, waits LATENCY cycles, then commits stores and returns extended loads.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [63:0]     addr_q, addr_d;
    logic [2:0]      size_q, size_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [63:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            acc_wr, illegal, misal, oor, err, enter, mem_we;
    logic [63:0]     acc_addr, acc_wdata, nb, raw, ext, load_data;
    logic [2:0]      acc_size;
    logic [AW-1:0]   base;

    // With LATENCY=1 the access happens on the accept edge, so it uses the live request fields.
    always_comb begin
        acc_wr    = state_q == IDLE ? req_write : wr_q;
        acc_addr  = state_q == IDLE ? req_addr  : addr_q;
        acc_size  = state_q == IDLE ? req_size  : size_q;
        acc_wdata = state_q == IDLE ? req_wdata : wdata_q;
        nb        = 64'(1) << acc_size[1:0];
        illegal   = acc_wr ? acc_size[2] : acc_size == 3'b111;
        misal     = |(acc_addr & (nb - 64'd1));
        oor       = acc_addr > 64'(DEPTH_BYTES) - nb;
        err       = illegal | misal | oor;
        base      = acc_addr[AW-1:0];
        raw       = '0;
        for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[base + AW'(i)];
        ext = acc_size == 3'd0 ? {{56{raw[7]}},  raw[7:0]}  :
              acc_size == 3'd1 ? {{48{raw[15]}}, raw[15:0]} :
              acc_size == 3'd2 ? {{32{raw[31]}}, raw[31:0]} :
              acc_size == 3'd4 ? {56'd0, raw[7:0]}          :
              acc_size == 3'd5 ? {48'd0, raw[15:0]}         :
              acc_size == 3'd6 ? {32'd0, raw[31:0]}         : raw;
        load_data = (err || acc_wr) ? 64'd0 : ext;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        enter        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    wr_d        = req_write;
                    addr_d      = req_addr;
                    size_d      = req_size;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        enter   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    enter   = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
            resp_err_d   = err;
        end
        mem_we = enter && acc_wr && !err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage is deliberately left out of reset; only the addressed 1/2/4/8 bytes are written.
    always_ff @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < 8; i++)
                if (64'(i) < nb) mem[base + AW'(i)] <= acc_wdata[8*i +: 8];
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder.
// Instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT [2] = '{2, 1};

    logic        clk = 1'b0;
    logic [1:0]  rst_n, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [63:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic [63:0] resp_rdata [2];
    logic [2:0]  req_size [2];
    logic [64:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) u0 (
        .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u1 (
        .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic wait_ready(input int d, input string nm);
        int n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready[d] !== 1'b1) begin
            $display("FAIL %s ready-timeout: req_ready=%b want 1", nm, req_ready[d]);
            errors++;
        end
    endtask

    task automatic drive(input int d, input bit w, input logic [2:0] sz, input logic [63:0] a,
                         input logic [63:0] wd);
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_size[d]  = sz;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        @(posedge clk);
        #1;
        // Scramble the request fields: the responder must have latched them already.
        req_valid[d] = 1'b0;
        req_write[d] = ~w;
        req_size[d]  = ~sz;
        req_addr[d]  = ~a;
        req_wdata[d] = ~wd;
    endtask

    task automatic xact(input int d, input bit w, input logic [2:0] sz, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] er, input bit ee,
                        input int stall, input string nm);
        int n;
        logic [63:0] held;
        logic [64:0] exp;
        exp_q.push_back({ee, er});
        wait_ready(d, nm);
        @(negedge clk);
        drive(d, w, sz, a, wd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_valid[d] !== 1'b1 && n < 20);
        checks++;
        if (n != LAT[d] || resp_valid[d] !== 1'b1) begin
            $display("FAIL %s latency: got %0d cycles (valid=%b) want %0d", nm, n, resp_valid[d], LAT[d]);
            errors++;
        end
        held = resp_rdata[d];
        for (int i = 0; i < stall; i++) begin
            checks++;
            if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== held || req_ready[d] !== 1'b0) begin
                $display("FAIL %s stall%0d: valid=%b rdata=%h ready=%b want 1 %h 0",
                         nm, i, resp_valid[d], resp_rdata[d], req_ready[d], held);
                errors++;
            end
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({resp_err[d], resp_rdata[d]} !== exp) begin
            $display("FAIL %s data: err=%b rdata=%h want err=%b rdata=%h",
                     nm, resp_err[d], resp_rdata[d], exp[64], exp[63:0]);
            errors++;
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            $display("FAIL %s handshake: valid=%b ready=%b want 0 1", nm, resp_valid[d], req_ready[d]);
            errors++;
        end
    endtask

    task automatic check_idle_outputs(input int d, input string nm);
        checks++;
        if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 64'd0 || resp_err[d] !== 1'b0) begin
            $display("FAIL %s: ready=%b valid=%b rdata=%h err=%b want all 0",
                     nm, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            errors++;
        end
    endtask

    task automatic release_reset(input int d, input string nm);
        @(negedge clk);
        rst_n[d] = 1'b1;
        #1;
        checks++;
        if (req_ready[d] !== 1'b0) begin
            $display("FAIL %s early-ready: req_ready=%b want 0", nm, req_ready[d]);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (req_ready[d] !== 1'b1) begin
            $display("FAIL %s ready-rise: req_ready=%b want 1", nm, req_ready[d]);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n = 2'b00;
        req_valid = '0;
        req_write = '0;
        resp_ready = '0;
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = '0;
            req_size[d] = '0;
            req_wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset0");
        check_idle_outputs(1, "reset1");
        release_reset(0, "reset0");
        release_reset(1, "reset1");
    endtask

    task automatic test_latency_stall();
        xact(0, 1, 3'b011, 64'h10, 64'h8877665544332211, 64'd0, 0, 0, "sd_0x10");
        xact(0, 0, 3'b011, 64'h10, 64'd0, 64'h8877665544332211, 0, 3, "ld_0x10_stall");
    endtask

    task automatic test_extension();
        xact(0, 1, 3'b011, 64'h20, 64'h00000000F0FF80FF, 64'd0, 0, 0, "sd_0x20");
        xact(0, 0, 3'b000, 64'h20, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0, 0, "lb_0x20");
        xact(0, 0, 3'b100, 64'h21, 64'd0, 64'h0000000000000080, 0, 0, "lbu_0x21");
        xact(0, 0, 3'b001, 64'h22, 64'd0, 64'hFFFFFFFFFFFFF0FF, 0, 0, "lh_0x22");
        xact(0, 0, 3'b101, 64'h22, 64'd0, 64'h000000000000F0FF, 0, 0, "lhu_0x22");
        xact(0, 0, 3'b010, 64'h20, 64'd0, 64'hFFFFFFFFF0FF80FF, 0, 0, "lw_0x20");
        xact(0, 0, 3'b110, 64'h20, 64'd0, 64'h00000000F0FF80FF, 0, 1, "lwu_0x20");
    endtask

    task automatic test_partial_store();
        xact(0, 1, 3'b011, 64'h30, 64'd0, 64'd0, 0, 0, "sd_0x30");
        xact(0, 1, 3'b000, 64'h33, 64'h11223344556677AB, 64'd0, 0, 0, "sb_0x33");
        xact(0, 1, 3'b001, 64'h36, 64'h55667788CAFE1234, 64'd0, 0, 0, "sh_0x36");
        xact(0, 0, 3'b011, 64'h30, 64'd0, 64'h12340000AB000000, 0, 0, "ld_0x30");
    endtask

    task automatic test_errors();
        xact(0, 1, 3'b011, 64'h40, 64'h0123456789ABCDEF, 64'd0, 0, 0, "sd_0x40");
        xact(0, 1, 3'b011, 64'(DEPTH - 8), 64'h5555AAAA5555AAAA, 64'd0, 0, 0, "sd_top");
        xact(0, 1, 3'b011, 64'h0, 64'h0F0E0D0C0B0A0908, 64'd0, 0, 0, "sd_0x0");
        xact(0, 0, 3'b010, 64'h42, 64'd0, 64'd0, 1, 0, "lw_misaligned");
        xact(0, 0, 3'b011, 64'(DEPTH - 4), 64'd0, 64'd0, 1, 0, "ld_out_of_range");
        xact(0, 0, 3'b010, 64'(DEPTH), 64'd0, 64'd0, 1, 0, "lw_at_depth");
        xact(0, 0, 3'b111, 64'h40, 64'd0, 64'd0, 1, 0, "load_f3_111");
        xact(0, 1, 3'b100, 64'h40, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 0, "store_f3_100");
        xact(0, 1, 3'b001, 64'h41, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 0, "sh_misaligned");
        xact(0, 1, 3'b011, 64'h1_0000_0000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 0, "sd_high_addr");
        xact(0, 0, 3'b011, 64'h40, 64'd0, 64'h0123456789ABCDEF, 0, 0, "reread_0x40");
        xact(0, 0, 3'b011, 64'(DEPTH - 8), 64'd0, 64'h5555AAAA5555AAAA, 0, 0, "reread_top");
        xact(0, 0, 3'b011, 64'h0, 64'd0, 64'h0F0E0D0C0B0A0908, 0, 0, "reread_0x0");
        xact(0, 0, 3'b100, 64'(DEPTH - 1), 64'd0, 64'h55, 0, 0, "lbu_last_byte");
    endtask

    task automatic test_reset_busy();
        xact(0, 1, 3'b011, 64'h50, 64'h1111, 64'd0, 0, 0, "sd_0x50_pre");
        wait_ready(0, "busy_store");
        @(negedge clk);
        drive(0, 1, 3'b011, 64'h50, 64'hDEAD);
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        check_idle_outputs(0, "reset_in_busy");
        release_reset(0, "reset_in_busy");
        xact(0, 0, 3'b011, 64'h50, 64'd0, 64'h1111, 0, 0, "ld_0x50_uncommitted");
    endtask

    task automatic test_reset_resp();
        xact(1, 1, 3'b011, 64'h50, 64'h2222, 64'd0, 0, 0, "l1_sd_0x50_pre");
        xact(1, 0, 3'b011, 64'h50, 64'd0, 64'h2222, 0, 2, "l1_ld_0x50_pre");
        wait_ready(1, "resp_store");
        @(negedge clk);
        drive(1, 1, 3'b011, 64'h50, 64'hDEAD);
        checks++;
        if (resp_valid[1] !== 1'b1) begin
            $display("FAIL l1_in_resp: resp_valid=%b want 1", resp_valid[1]);
            errors++;
        end
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        check_idle_outputs(1, "reset_in_resp");
        release_reset(1, "reset_in_resp");
        xact(1, 0, 3'b011, 64'h50, 64'd0, 64'hDEAD, 0, 0, "l1_ld_0x50_committed");
    endtask

    initial begin
        test_reset();
        test_latency_stall();
        test_extension();
        test_partial_store();
        test_errors();
        test_reset_busy();
        test_reset_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
